seg_scan_display: RTL and testbench

//   Reader/display end of the 16-bit nibble-edited number bus: takes num[15:0]
//   and shows it as 4 hex digits on a multiplexed, common-anode 7-segment display.

---
 rtl/seg_scan_display.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_display.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Scans a 16-bit value onto a 4-digit multiplexed common-anode
//               7-segment display, one hex digit at a time. The value and
//               its decimal points are captured once per frame so a frame
//               never shows a mix of old and new digits.
//               Optional build macro: LEADING_ZERO_BLANK_EN. When it is
//               defined, zero digits above the most significant nonzero
//               digit are blanked.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
  parameter int SCAN_DIV_W = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] num,
  input  logic [3:0]  point,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_scan = 1'b1;
  localparam logic [SCAN_DIV_W-1:0] c_cnt_max = '1;

  logic [0:0]            state_q, state_d;
  logic [SCAN_DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]            dig_q, dig_d;
  logic [15:0]           snum_q, snum_d;
  logic [3:0]            spt_q, spt_d;
  logic [3:0]            an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic [3:0]            w_nib;
  logic [7:0]            w_dec;
  logic [3:0]            w_blank;

  // Hex to segment pattern, active-low {dp,g,f,e,d,c,b,a}, with dp off.
  function automatic logic [7:0] hex_decode(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign w_nib = snum_q[{dig_q, 2'b00} +: 4];
  assign w_dec = hex_decode(w_nib);

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked when it and every digit above it are zero, unless it
  // is digit 0 or carries a lit decimal point.
  generate
    for (genvar d = 0; d < 4; d++) begin : g_blank
      if (d == 0) begin : g_d0
        assign w_blank[d] = 1'b0;
      end else begin : g_dn
        assign w_blank[d] = ~spt_q[d] & ~(|snum_q[15:4*d]);
      end
    end
  endgenerate
`else
  assign w_blank = 4'b0000;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: scanning follows the enable input.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (en)  state_d = c_scan;
      c_scan:  if (!en) state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // Next outputs and scan datapath: divider, digit index and frame snapshot.
  always_comb begin
    an_d   = 4'b1111;
    seg_d  = 8'hFF;
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    snum_d = snum_q;
    spt_d  = spt_q;
    case (state_q)
      c_idle: begin
        if (en) begin
          cnt_d  = '0;
          dig_d  = 2'd0;
          snum_d = num;
          spt_d  = point;
        end
      end
      c_scan: begin
        if (en) begin
          if (!w_blank[dig_q]) begin
            an_d  = ~(4'b0001 << dig_q);
            seg_d = {~spt_q[dig_q], w_dec[6:0]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == c_cnt_max) begin
            dig_d = dig_q + 2'd1;
            // Last slot of the frame ends: the next frame uses fresh inputs.
            if (dig_q == 2'd3) begin
              snum_d = num;
              spt_d  = point;
            end
          end
        end else begin
          cnt_d = '0;
          dig_d = 2'd0;
        end
      end
      default: begin
        cnt_d = '0;
        dig_d = 2'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dig_q  <= 2'd0;
      snum_q <= 16'h0000;
      spt_q  <= 4'b0000;
      an_q   <= 4'b1111;
      seg_q  <= 8'hFF;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      snum_q <= snum_d;
      spt_q  <= spt_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_display
// Description : Self-checking bench for seg_scan_display with a 4-cycle slot.
//               A timeline model predicts what the display shows on every
//               clock edge from the number of edges since scanning began.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_display;

  localparam int W     = 2;
  localparam int SLOT  = 1 << W;
  localparam int FRAME = 4 * SLOT;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic [15:0] num   = 16'h0000;
  logic [3:0]  point = 4'b0000;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;
  bit clk_run = 1'b1;

  // Timeline model state.
  int          m_k = 0;
  logic [15:0] m_num = 16'h0000;
  logic [3:0]  m_pt = 4'b0000;
  logic [3:0]  m_an = 4'b1111;
  logic [7:0]  m_seg = 8'hFF;

  logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_display #(.SCAN_DIV_W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .num  (num),
    .point(point),
    .an   (an),
    .seg  (seg)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // What digit d of the captured value looks like on the pins.
  task automatic disp(input int d);
    logic [15:0] upper;
    logic [7:0]  pat;
    bit          blank;
    blank = 1'b0;
    upper = m_num >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && !m_pt[d] && upper == 16'h0000) blank = 1'b1;
`endif
    if (blank) begin
      m_an  = 4'b1111;
      m_seg = 8'hFF;
    end else begin
      pat   = dec_tab[upper[3:0]];
      m_an  = ~(4'b0001 << d);
      m_seg = {~m_pt[d], pat[6:0]};
    end
  endtask

  // Advance one clock edge and update the expected outputs. Edge 1 after
  // enabling captures the value; edge 2+16f+4d shows digit d of frame f.
  task automatic step();
    int p;
    @(posedge clk);
    if (!en) begin
      m_k = 0;
      m_an = 4'b1111;
      m_seg = 8'hFF;
    end else if (m_k == 0) begin
      m_num = num;
      m_pt  = point;
      m_an  = 4'b1111;
      m_seg = 8'hFF;
      m_k   = 1;
    end else begin
      p = (m_k - 1) % FRAME;
      disp(p / SLOT);
      if (p == FRAME - 1) begin
        m_num = num;
        m_pt  = point;
      end
      m_k++;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want FF", seg); end
    checks++;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (an !== 4'b1111 || seg !== 8'hFF) begin
      errors++; $display("FAIL reset_held got an=%b seg=%h want 1111/FF", an, seg);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    m_k = 0;
  endtask

  task automatic test_basic_frame();
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] es [4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    num = 16'hABCD; point = 4'b0000; en = 1'b1;
    step();
    if (an !== 4'b1111 || seg !== 8'hFF) begin
      errors++; $display("FAIL basic_idle_edge got an=%b seg=%h want 1111/FF", an, seg);
    end
    checks++;
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < SLOT; c++) begin
          step();
          if (an !== ea[d] || seg !== es[d]) begin
            errors++;
            $display("FAIL basic_digit%0d got an=%b seg=%h want %b/%h", d, an, seg, ea[d], es[d]);
          end
          checks++;
          if (an !== m_an || seg !== m_seg) begin
            errors++;
            $display("FAIL basic_model got an=%b seg=%h want %b/%h", an, seg, m_an, m_seg);
          end
          checks++;
        end
  endtask

  task automatic test_frame_snapshot();
    logic [7:0] es [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int i = 0; i < 8 * SLOT; i++) begin
      step();
      if (i == SLOT) num = 16'h1234;
      if (seg !== es[i / SLOT]) begin
        errors++; $display("FAIL snapshot_slot%0d got seg=%h want %h", i / SLOT, seg, es[i / SLOT]);
      end
      checks++;
      if (an !== m_an || seg !== m_seg) begin
        errors++;
        $display("FAIL snapshot_model got an=%b seg=%h want %b/%h", an, seg, m_an, m_seg);
      end
      checks++;
    end
  endtask

  task automatic test_disable();
    repeat (SLOT + 2) step();
    en = 1'b0;
    step();
    if (an !== 4'b1111 || seg !== 8'hFF) begin
      errors++; $display("FAIL disable_blank got an=%b seg=%h want 1111/FF", an, seg);
    end
    checks++;
    step();
    en = 1'b1;
    step();
    step();
    if (an !== 4'b1110 || seg !== 8'h99) begin
      errors++; $display("FAIL reenable_digit0 got an=%b seg=%h want 1110/99", an, seg);
    end
    checks++;
    if (an !== m_an || seg !== m_seg) begin
      errors++; $display("FAIL reenable_model got an=%b seg=%h want %b/%h", an, seg, m_an, m_seg);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    repeat (SLOT + 1) step();
    @(negedge clk);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    if (an !== 4'b1111 || seg !== 8'hFF) begin
      errors++; $display("FAIL async_reset got an=%b seg=%h want 1111/FF", an, seg);
    end
    checks++;
    #20 rst_n = 1'b1;
    m_k = 0;
    #3 clk_run = 1'b1;
    step();
    step();
    if (an !== 4'b1110 || seg !== m_seg) begin
      errors++; $display("FAIL async_restart got an=%b seg=%h want 1110/%h", an, seg, m_seg);
    end
    checks++;
  endtask

  task automatic test_point();
    en = 1'b0;
    step();
    num = 16'hABCD; point = 4'b0100; en = 1'b1;
    step();
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < SLOT; c++) begin
        step();
        if (seg[7] !== (d == 2 ? 1'b0 : 1'b1)) begin
          errors++; $display("FAIL point_dp_digit%0d got seg=%h", d, seg);
        end
        checks++;
        if (d == 2 && seg !== 8'h03) begin
          errors++; $display("FAIL point_digit2 got seg=%h want 03", seg);
        end
        if (d == 2) checks++;
        if (an !== m_an || seg !== m_seg) begin
          errors++; $display("FAIL point_model got an=%b seg=%h want %b/%h", an, seg, m_an, m_seg);
        end
        checks++;
      end
  endtask

  task automatic test_leading_zero();
    logic [3:0] want_an;
    logic [7:0] want_seg;
    en = 1'b0;
    step();
    num = 16'h000F; point = 4'b0000; en = 1'b1;
    step();
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < SLOT; c++) begin
        step();
        if (d == 0) begin
          want_an = 4'b1110; want_seg = 8'h8E;
        end else begin
`ifdef LEADING_ZERO_BLANK_EN
          want_an = 4'b1111; want_seg = 8'hFF;
`else
          want_an = ~(4'b0001 << d); want_seg = 8'hC0;
`endif
        end
        if (an !== want_an || seg !== want_seg) begin
          errors++;
          $display("FAIL lzero_digit%0d got an=%b seg=%h want %b/%h", d, an, seg, want_an, want_seg);
        end
        checks++;
      end
  endtask

  task automatic test_random();
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) num = 16'($urandom) & masks[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) point = 4'($urandom);
      if ($urandom_range(0, 59) == 0) en = ~en;
      step();
      if (an !== m_an || seg !== m_seg) begin
        errors++; $display("FAIL random_model got an=%b seg=%h want %b/%h", an, seg, m_an, m_seg);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_frame_snapshot();
    test_disable();
    test_async_reset();
    test_point();
    test_leading_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
